// File: rtl/infra_reset_sequencer.sv
// Reset-release sequencer: qualifies PLL lock and an auxiliary ready, holds, then releases
// NUM_CH reset domains in order, with soft re-sequence, lock-loss recovery and a ready timeout.
//   state     | meaning
//   WAIT_LOCK | all domains in reset, waiting for synchronised lock
//   LOCK_FILT | lock seen, requiring LOCK_FILTER consecutive cycles
//   HOLD      | lock qualified, holding all domains for HOLD_CYCLES
//   WAIT_RDY  | waiting for auxiliary ready (optionally bounded)
//   RELEASE   | releasing one domain every STAGE_GAP cycles
//   RUN       | all domains released
module infra_reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 65535,
  parameter int STAGE_GAP   = 256,
  parameter int RDY_TIMEOUT = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pll_lock,
  input  logic              aux_rdy,
  input  logic              soft_rst,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              all_released,
  output logic [2:0]        seq_state,
  output logic [7:0]        lock_loss_cnt,
  output logic              rdy_timeout
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
  localparam int     IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || SYNC_STAGES < 2 || LOCK_FILTER < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1 ||
      RDY_TIMEOUT < 0 || longint'(LOCK_FILTER) > CNT_MAX || longint'(HOLD_CYCLES) > CNT_MAX ||
      longint'(STAGE_GAP) > CNT_MAX || longint'(RDY_TIMEOUT) > CNT_MAX) begin : g_bad_param
    $error("infra_reset_sequencer: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] LF_LAST   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_LOCK_FILT = 3'd1,
    S_HOLD      = 3'd2,
    S_WAIT_RDY  = 3'd3,
    S_RELEASE   = 3'd4,
    S_RUN       = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] r_rdy_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_CH-1:0]      r_ch_rst;
  logic                   r_all_rel;
  logic [7:0]             r_loss;
  logic                   r_timeout;

  logic                   w_lock_s;
  logic                   w_rdy_s;
  logic                   w_qualified;
  logic                   w_lock_lost;
  logic                   w_soft_go;
  logic                   w_timeout_hit;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [NUM_CH-1:0]      w_ch_rst_nxt;
  logic                   w_all_rel_nxt;
  logic [7:0]             w_loss_nxt;
  logic                   w_timeout_nxt;

  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
  assign w_rdy_s  = r_rdy_sync[SYNC_STAGES-1];

  // State, counters, synchronisers and every output are registered here.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_lock_sync <= '0;
      r_rdy_sync  <= '0;
      r_state     <= S_WAIT_LOCK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_ch_rst    <= '1;
      r_all_rel   <= 1'b0;
      r_loss      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_lock};
      r_rdy_sync  <= {r_rdy_sync[SYNC_STAGES-2:0], aux_rdy};
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_ch_rst    <= w_ch_rst_nxt;
      r_all_rel   <= w_all_rel_nxt;
      r_loss      <= w_loss_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_lock_lost   = 1'b0;
    w_soft_go     = 1'b0;
    w_timeout_hit = 1'b0;
    w_qualified   = (r_state == S_HOLD) || (r_state == S_WAIT_RDY) ||
                    (r_state == S_RELEASE) || (r_state == S_RUN);
    // Lock loss outranks a coincident soft reset.
    if (w_qualified && !w_lock_s) begin
      w_state_nxt = S_WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_lock_lost = 1'b1;
    end else if (w_qualified && soft_rst) begin
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_soft_go   = 1'b1;
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nxt = S_LOCK_FILT;
            w_cnt_nxt   = '0;
          end
        end
        S_LOCK_FILT: begin
          if (!w_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == LF_LAST) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = S_WAIT_RDY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_RDY: begin
          if (w_rdy_s || (RDY_TIMEOUT != 0 && r_cnt == TO_LAST)) begin
            w_state_nxt   = S_RELEASE;
            w_cnt_nxt     = '0;
            w_idx_nxt     = '0;
            w_timeout_hit = !w_rdy_s;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (r_cnt == GAP_LAST) begin
            w_cnt_nxt = '0;
            if (r_idx == IDX_LAST) begin
              w_state_nxt = S_RUN;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_ch_rst_nxt  = r_ch_rst;
    w_all_rel_nxt = r_all_rel;
    w_loss_nxt    = r_loss;
    w_timeout_nxt = r_timeout;
    if (w_lock_lost) begin
      w_ch_rst_nxt  = '1;
      w_all_rel_nxt = 1'b0;
      if (r_loss != 8'hFF) w_loss_nxt = r_loss + 8'd1;
    end else if (w_soft_go) begin
      w_ch_rst_nxt  = '1;
      w_all_rel_nxt = 1'b0;
      w_timeout_nxt = 1'b0;
    end else if (w_state_nxt == S_RELEASE) begin
      // Clearing the current stage bit every cycle is idempotent and keeps release in order.
      w_ch_rst_nxt[w_idx_nxt] = 1'b0;
      if (w_timeout_hit) w_timeout_nxt = 1'b1;
    end else if (w_state_nxt == S_RUN) begin
      w_ch_rst_nxt  = '0;
      w_all_rel_nxt = 1'b1;
    end else begin
      w_ch_rst_nxt  = '1;
      w_all_rel_nxt = 1'b0;
    end
  end

  assign ch_rst        = r_ch_rst;
  assign all_released  = r_all_rel;
  assign seq_state     = r_state;
  assign lock_loss_cnt = r_loss;
  assign rdy_timeout   = r_timeout;

endmodule

// File: tb/tb_infra_reset_sequencer.sv
// Scoreboard bench: two sequencers (no ready timeout / 10-cycle timeout) share stimulus and are
// compared every cycle against a timestamp-based reference model.
module tb_infra_reset_sequencer;
  localparam int NUM_CH = 4;
  localparam int SYNC   = 2;
  localparam int LF     = 8;
  localparam int HOLD   = 16;
  localparam int GAP    = 4;
  localparam int TO_B   = 10;

  localparam int P_WL = 0, P_LF = 1, P_HOLD = 2, P_WR = 3, P_REL = 4, P_RUN = 5;

  typedef struct packed {
    logic [NUM_CH-1:0] ch;
    logic              rel;
    logic [2:0]        st;
    logic [7:0]        loss;
    logic              tmo;
  } obs_t;

  localparam obs_t RST_OBS = '{ch: 4'hF, rel: 1'b0, st: 3'd0, loss: 8'd0, tmo: 1'b0};

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  logic pll_lock  = 1'b0;
  logic aux_rdy   = 1'b0;
  logic soft_rst  = 1'b0;

  logic [NUM_CH-1:0] a_ch, b_ch;
  logic              a_rel, b_rel, a_tmo, b_tmo;
  logic [2:0]        a_st, b_st;
  logic [7:0]        a_loss, b_loss;
  obs_t              obs_a, obs_b;

  assign obs_a = {a_ch, a_rel, a_st, a_loss, a_tmo};
  assign obs_b = {b_ch, b_rel, b_st, b_loss, b_tmo};

  infra_reset_sequencer #(
    .NUM_CH(NUM_CH), .CNT_W(16), .SYNC_STAGES(SYNC), .LOCK_FILTER(LF),
    .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .RDY_TIMEOUT(0)
  ) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock), .aux_rdy(aux_rdy),
    .soft_rst(soft_rst), .ch_rst(a_ch), .all_released(a_rel), .seq_state(a_st),
    .lock_loss_cnt(a_loss), .rdy_timeout(a_tmo)
  );

  infra_reset_sequencer #(
    .NUM_CH(NUM_CH), .CNT_W(16), .SYNC_STAGES(SYNC), .LOCK_FILTER(LF),
    .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .RDY_TIMEOUT(TO_B)
  ) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock), .aux_rdy(aux_rdy),
    .soft_rst(soft_rst), .ch_rst(b_ch), .all_released(b_rel), .seq_state(b_st),
    .lock_loss_cnt(b_loss), .rdy_timeout(b_tmo)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  obs_t q_a[$];
  obs_t q_b[$];

  // Reference model: each phase remembers the edge it was entered on; exits and channel
  // releases are computed from elapsed edges rather than from a running counter.
  int               m_t;
  int               m_phase[2];
  int               m_t0[2];
  int               m_loss[2];
  bit               m_tmo[2];
  logic [SYNC-1:0]  m_ls[2];
  logic [SYNC-1:0]  m_rs[2];

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got ch=%h rel=%0d st=%0d loss=%0d tmo=%0d, expected ch=%h rel=%0d st=%0d loss=%0d tmo=%0d",
               name, $time, act.ch, act.rel, act.st, act.loss, act.tmo,
               exp.ch, exp.rel, exp.st, exp.loss, exp.tmo);
    end
  endtask

  task automatic model_step(input int d, input int tlim, input bit lk, input bit rd,
                            input bit sf, input bit rn, output obs_t o);
    bit ls, rs, qual;
    int el;
    if (!rn) begin
      m_phase[d] = P_WL; m_t0[d] = 0; m_loss[d] = 0; m_tmo[d] = 0;
      m_ls[d] = '0; m_rs[d] = '0;
    end else begin
      ls   = m_ls[d][SYNC-1];
      rs   = m_rs[d][SYNC-1];
      el   = m_t - m_t0[d];
      qual = (m_phase[d] >= P_HOLD);
      if (qual && !ls) begin
        m_phase[d] = P_WL;
        if (m_loss[d] < 255) m_loss[d]++;
      end else if (qual && sf) begin
        m_phase[d] = P_HOLD; m_t0[d] = m_t; m_tmo[d] = 0;
      end else begin
        case (m_phase[d])
          P_WL:   if (ls) begin m_phase[d] = P_LF; m_t0[d] = m_t; end
          P_LF:   if (!ls) m_phase[d] = P_WL;
                  else if (el == LF) begin m_phase[d] = P_HOLD; m_t0[d] = m_t; end
          P_HOLD: if (el == HOLD) begin m_phase[d] = P_WR; m_t0[d] = m_t; end
          P_WR:   if (rs) begin m_phase[d] = P_REL; m_t0[d] = m_t; end
                  else if (tlim != 0 && el == tlim) begin
                    m_phase[d] = P_REL; m_t0[d] = m_t; m_tmo[d] = 1;
                  end
          P_REL:  if (el == NUM_CH * GAP) m_phase[d] = P_RUN;
          default: ;
        endcase
      end
      m_ls[d] = {m_ls[d][SYNC-2:0], lk};
      m_rs[d] = {m_rs[d][SYNC-2:0], rd};
    end
    o.ch = '1;
    if (m_phase[d] == P_REL) begin
      for (int k = 0; k < NUM_CH; k++)
        if (m_t - m_t0[d] >= k * GAP) o.ch[k] = 1'b0;
    end else if (m_phase[d] == P_RUN) begin
      o.ch = '0;
    end
    o.rel  = (m_phase[d] == P_RUN);
    o.st   = 3'(m_phase[d]);
    o.loss = 8'(m_loss[d]);
    o.tmo  = m_tmo[d];
  endtask

  // One clock of stimulus: inputs change on the falling edge, expectation for the next rising edge is queued.
  task automatic step(input bit lk, input bit rd, input bit sf, input bit rn);
    obs_t ea, eb;
    @(negedge sys_clk);
    pll_lock = lk; aux_rdy = rd; soft_rst = sf;
    if (sys_rst_n && !rn) begin
      sys_rst_n = 1'b0;
      #1;
      chk("async_rst_a", obs_a, RST_OBS);
      chk("async_rst_b", obs_b, RST_OBS);
    end else begin
      sys_rst_n = rn;
    end
    model_step(0, 0, lk, rd, sf, rn, ea);
    model_step(1, TO_B, lk, rd, sf, rn, eb);
    m_t++;
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (q_a.size() > 0) chk("cycle_a", obs_a, q_a.pop_front());
      if (q_b.size() > 0) chk("cycle_b", obs_b, q_b.pop_front());
    end
  end

  initial begin
    bit lk, rd, sf, rn;
    m_t = 0;
    #1 sys_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // nominal bring-up into RUN
    for (int i = 0; i < 50; i++) step(1, 1, 0, 1);
    // lock loss in RUN, then a one-cycle glitch inside the filter window
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    for (int i = 0; i < 50; i++) step(1, 1, 0, 1);
    // soft reset while stage index is 1
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
    for (int i = 0; i < 75; i++) step(1, 1, (i == 32), 1);
    // soft reset on the same edge the synchronised lock is seen low
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    // late ready: unbounded instance waits, bounded one times out
    for (int i = 0; i < 100; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 30; i++) step(1, 1, 0, 1);
    // soft reset clears the sticky timeout
    step(1, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1);
    // async reset in the middle of RELEASE, then a full restart
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
    for (int i = 0; i < 31; i++) step(1, 1, 0, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 50; i++) step(1, 1, 0, 1);
    // lock-loss counter saturation
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 14; i++) step(1, 1, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
    end
    // randomised traffic
    lk = 1; rd = 1; rn = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) lk = !lk;
      if ($urandom_range(0, 29) == 0) rd = !rd;
      sf = ($urandom_range(0, 99) == 0);
      rn = ($urandom_range(0, 1999) != 0);
      step(lk, rd, sf, rn);
    end
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
    @(posedge sys_clk);
    #3;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0/0", q_a.size(), q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
